ahb_bram_slave: RTL and testbench



---
 rtl/ahb_bram_pkg.sv | 40 ++++
 rtl/ahb_bram_slave_bram_be_sp.sv | 34 +++
 rtl/ahb_bram_slave.sv | 166 ++++++++++++++++
 tb/tb_ahb_bram_slave.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_bram_pkg.sv
// Shared AHB-Lite encodings, FSM state constants and the byte-lane strobe helper
// used by the BRAM slave.
package ahb_bram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RWAIT = 2'd1;
  localparam logic [1:0] ST_ERR1  = 2'd2;
  localparam logic [1:0] ST_ERR2  = 2'd3;

  // Contiguous run of 2^hsize lanes starting at addr_lsbs, clipped to the bus width.
  function automatic logic [7:0] lane_strobe(input logic [2:0] addr_lsbs,
                                             input logic [2:0] hsize,
                                             input int         lanes);
    logic [7:0] mask;
    int         first;
    int         count;
    mask  = 8'h00;
    first = int'(addr_lsbs);
    count = 32'sd1 << hsize;
    for (int i = 0; i < 8; i++) begin
      if ((i >= first) && (i < first + count) && (i < lanes)) begin
        mask[i] = 1'b1;
      end else begin
        mask[i] = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/ahb_bram_slave_bram_be_sp.sv
// Synchronous byte-lane RAM: one write address and one read address per cycle;
// a read of the word being written returns the old contents.
module bram_be_sp #(
  parameter int DEPTH = 7168,
  parameter int LANES = 4,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 i_clk,
  input  logic [LANES-1:0]     i_we,
  input  logic [AW-1:0]        i_waddr,
  input  logic [LANES*8-1:0]   i_wdata,
  input  logic                 i_re,
  input  logic [AW-1:0]        i_raddr,
  output logic [LANES*8-1:0]   o_rdata
);

  logic [LANES-1:0][7:0] r_mem [DEPTH];
  logic [LANES-1:0][7:0] r_rdata;

  // Per-lane write and registered read; contents are never reset.
  always_ff @(posedge i_clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (i_we[l]) begin
        r_mem[i_waddr][l] <= i_wdata[l*8 +: 8];
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ahb_bram_slave.sv
// AHB-Lite slave in front of a byte-lane BRAM: strobed writes, optional read wait
// states, read-after-write bypass and a two-cycle ERROR response.
module ahb_bram_slave
  import ahb_bram_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_BYTES   = 28672,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HSEL,
  input  logic                    HREADY,
  input  logic [1:0]              HTRANS,
  input  logic [2:0]              HSIZE,
  input  logic                    HWRITE,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [DATA_WIDTH-1:0]   HRDATA
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(LANES);
  localparam int DEPTH = MEM_BYTES / LANES;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [1:0] WS_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;
  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_BYTES);

  logic                  w_accept;
  logic                  w_err;
  logic                  w_misalign;
  logic [7:0]            w_align_mask;
  logic [AW-1:0]         w_word;
  logic [LANES-1:0]      w_strb;
  logic                  w_rd_go;
  logic                  w_wr_go;
  logic                  w_raw_hit;
  logic [1:0]            w_state_nxt;
  logic [1:0]            w_cnt_nxt;
  logic [LANES-1:0]      w_ram_we;
  logic [DATA_WIDTH-1:0] w_ram_rdata;
  logic [DATA_WIDTH-1:0] w_rdata;

  logic [1:0]            r_state;
  logic [1:0]            r_cnt;
  logic                  r_hreadyout;
  logic                  r_hresp;
  logic                  r_wr_pend;
  logic [AW-1:0]         r_word;
  logic [LANES-1:0]      r_strb;
  logic                  r_rd_valid;
  logic [LANES-1:0]      r_byp_strb;
  logic [DATA_WIDTH-1:0] r_byp_data;

  assign w_accept     = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign w_align_mask = (8'd1 << HSIZE) - 8'd1;
  assign w_misalign   = |(HADDR[7:0] & w_align_mask);
  assign w_err        = (HADDR >= MEM_LIMIT) | (HSIZE > 3'(LSB)) | w_misalign;
  assign w_word       = HADDR[LSB +: AW];
  assign w_strb       = LANES'(lane_strobe(3'(HADDR[LSB-1:0]), HSIZE, LANES));
  assign w_rd_go      = w_accept & ~HWRITE & ~w_err;
  assign w_wr_go      = w_accept &  HWRITE & ~w_err;
  // A read landing on the word whose write data phase is ending this cycle.
  assign w_raw_hit    = w_rd_go & r_wr_pend & (r_word == w_word);
  assign w_ram_we     = r_wr_pend ? r_strb : {LANES{1'b0}};

  bram_be_sp #(
    .DEPTH (DEPTH),
    .LANES (LANES),
    .AW    (AW)
  ) u_ram (
    .i_clk   (HCLK),
    .i_we    (w_ram_we),
    .i_waddr (r_word),
    .i_wdata (HWDATA),
    .i_re    (w_rd_go),
    .i_raddr (w_word),
    .o_rdata (w_ram_rdata)
  );

  // Next-state and wait-counter logic; ERR2 can take a new address phase like IDLE.
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RWAIT: begin
        if (r_cnt == 2'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RWAIT;
          w_cnt_nxt   = r_cnt - 2'd1;
        end
      end
      ST_ERR1: begin
        w_state_nxt = ST_ERR2;
      end
      ST_IDLE, ST_ERR2: begin
        if (w_accept && w_err) begin
          w_state_nxt = ST_ERR1;
        end else if (w_rd_go && HAS_WAIT) begin
          w_state_nxt = ST_RWAIT;
          w_cnt_nxt   = WS_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM, registered handshake outputs and write/bypass phase registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 2'd0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_word      <= {AW{1'b0}};
      r_strb      <= {LANES{1'b0}};
      r_rd_valid  <= 1'b0;
      r_byp_strb  <= {LANES{1'b0}};
      r_byp_data  <= {DATA_WIDTH{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hreadyout <= (w_state_nxt == ST_IDLE) | (w_state_nxt == ST_ERR2);
      r_hresp     <= (w_state_nxt == ST_ERR1) | (w_state_nxt == ST_ERR2);
      r_wr_pend   <= w_wr_go;
      if (w_wr_go) begin
        r_word <= w_word;
        r_strb <= w_strb;
      end
      if (w_rd_go) begin
        r_rd_valid <= 1'b1;
        r_byp_strb <= w_raw_hit ? r_strb : {LANES{1'b0}};
        r_byp_data <= HWDATA;
      end
    end
  end

  // Merge bypassed write lanes over the RAM word; zero until the first read.
  always_comb begin
    w_rdata = {DATA_WIDTH{1'b0}};
    for (int l = 0; l < LANES; l++) begin
      if (!r_rd_valid) begin
        w_rdata[l*8 +: 8] = 8'h00;
      end else if (r_byp_strb[l]) begin
        w_rdata[l*8 +: 8] = r_byp_data[l*8 +: 8];
      end else begin
        w_rdata[l*8 +: 8] = w_ram_rdata[l*8 +: 8];
      end
    end
  end

  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;
  assign HRDATA    = w_rdata;

endmodule

// File: tb/tb_ahb_bram_slave.sv
// Bench for ahb_bram_slave: one zero-wait and one two-wait instance, table vectors,
// reset-in-flight sequences and random traffic against a byte-level memory model.
module tb_ahb_bram_slave;
  import ahb_bram_pkg::*;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          has_exp;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } txn_t;

  typedef struct {
    bit          valid;
    int          kind;      // 0 idle, 1 write, 2 read
    bit          err;
    bit          chk_data;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          waits;
    logic        first_resp;
  } dp_t;

  logic        clk;
  logic        rst_n     [2];
  logic        hsel      [2];
  logic        hready    [2];
  logic [1:0]  htrans    [2];
  logic [2:0]  hsize     [2];
  logic        hwrite    [2];
  logic [31:0] haddr     [2];
  logic [31:0] hwdata    [2];
  logic        hreadyout [2];
  logic        hresp     [2];
  logic [31:0] hrdata    [2];

  int n_vec;
  int n_err;
  txn_t tq[$];
  logic [7:0] mdl [int];

  assign hready[0] = hreadyout[0];
  assign hready[1] = hreadyout[1];

  ahb_bram_slave #(.DATA_WIDTH(32), .MEM_BYTES(28672), .WAIT_STATES(0), .ADDR_WIDTH(32)) u_dut0 (
    .HCLK(clk), .HRESETn(rst_n[0]), .HSEL(hsel[0]), .HREADY(hready[0]), .HTRANS(htrans[0]),
    .HSIZE(hsize[0]), .HWRITE(hwrite[0]), .HADDR(haddr[0]), .HWDATA(hwdata[0]),
    .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

  ahb_bram_slave #(.DATA_WIDTH(32), .MEM_BYTES(28672), .WAIT_STATES(2), .ADDR_WIDTH(32)) u_dut1 (
    .HCLK(clk), .HRESETn(rst_n[1]), .HSEL(hsel[1]), .HREADY(hready[1]), .HTRANS(htrans[1]),
    .HSIZE(hsize[1]), .HWRITE(hwrite[1]), .HADDR(haddr[1]), .HWDATA(hwdata[1]),
    .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic int key(input int d, input logic [31:0] a);
    return d * 65536 + int'(a);
  endfunction

  function automatic txn_t mk(input logic wr, input logic [31:0] a, input logic [2:0] s,
                              input logic [31:0] wd, input bit he, input bit ee,
                              input logic [31:0] er);
    txn_t t;
    t.sel = 1'b1; t.trans = HTRANS_NONSEQ; t.wr = wr; t.addr = a; t.size = s;
    t.wdata = wd; t.has_exp = he; t.exp_err = ee; t.exp_rdata = er;
    return t;
  endfunction

  function automatic txn_t mk_idle();
    txn_t t;
    t = mk(1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    t.trans = HTRANS_IDLE;
    return t;
  endfunction

  // Spec rules in plain arithmetic: out of range, too wide, or misaligned.
  function automatic bit model_err(input logic [31:0] a, input logic [2:0] s);
    return (a >= 32'd28672) || (s > 3'd2) || ((a % (32'd1 << s)) != 32'd0);
  endfunction

  task automatic model_write(input int d, input txn_t t);
    for (int b = 0; b < (1 << t.size); b++) begin
      logic [31:0] a;
      int lane;
      a = t.addr + b;
      lane = int'(a[1:0]);
      mdl[key(d, a)] = t.wdata[8*lane +: 8];
    end
  endtask

  task automatic model_read(input int d, input logic [31:0] a, output logic [31:0] r,
                            output bit known);
    logic [31:0] wb;
    wb = {a[31:2], 2'b00};
    known = 1'b1;
    r = 32'h0;
    for (int l = 0; l < 4; l++) begin
      if (mdl.exists(key(d, wb + l))) r[8*l +: 8] = mdl[key(d, wb + l)];
      else known = 1'b0;
    end
  endtask

  task automatic chk(input string name, input int d, input logic [31:0] addr,
                     input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d addr=%h got=%h expected=%h", name, d, addr, act, exp);
    end
  endtask

  task automatic chk_reset(input int d);
    chk("reset_hreadyout", d, 32'h0, {31'h0, hreadyout[d]}, 32'h1);
    chk("reset_hresp", d, 32'h0, {31'h0, hresp[d]}, 32'h0);
    chk("reset_hrdata", d, 32'h0, hrdata[d], 32'h0);
  endtask

  task automatic present(input int d, input int idx);
    if (idx < tq.size()) begin
      hsel[d] = tq[idx].sel; htrans[d] = tq[idx].trans; hwrite[d] = tq[idx].wr;
      haddr[d] = tq[idx].addr; hsize[d] = tq[idx].size;
    end else begin
      hsel[d] = 1'b0; htrans[d] = HTRANS_IDLE; hwrite[d] = 1'b0;
      haddr[d] = 32'h0; hsize[d] = 3'd0;
    end
  endtask

  task automatic accept(input int d, input txn_t t, output dp_t dp);
    bit merr;
    bit known;
    logic [31:0] r;
    dp.valid = 1'b1; dp.waits = 0; dp.first_resp = 1'b0; dp.addr = t.addr;
    dp.wdata = t.wr ? t.wdata : $urandom; dp.chk_data = 1'b0; dp.exp = 32'h0;
    if (!(t.sel && t.trans[1])) begin
      dp.kind = 0; dp.err = 1'b0;
    end else begin
      merr = model_err(t.addr, t.size);
      dp.kind = t.wr ? 1 : 2;
      dp.err = t.has_exp ? t.exp_err : merr;
      if (t.wr && !merr) model_write(d, t);
      if (!t.wr && !dp.err) begin
        if (t.has_exp) begin
          dp.exp = t.exp_rdata; dp.chk_data = 1'b1;
        end else begin
          model_read(d, t.addr, r, known);
          dp.exp = r; dp.chk_data = known;
        end
      end
    end
  endtask

  task automatic check_dp(input int d, input dp_t dp, input logic rsp, input logic [31:0] rd);
    int ew;
    ew = dp.err ? 1 : ((dp.kind == 2) ? ws_of(d) : 0);
    chk("wait_cycles", d, dp.addr, 32'(dp.waits), 32'(ew));
    chk("hresp_final", d, dp.addr, {31'h0, rsp}, {31'h0, dp.err});
    if (dp.err) chk("hresp_err1", d, dp.addr, {31'h0, dp.first_resp}, 32'h1);
    if (dp.chk_data) chk("hrdata", d, dp.addr, rd, dp.exp);
  endtask

  // Pipelined master: address of the next transfer overlaps the current data phase.
  task automatic run(input int d);
    dp_t dp;
    int idx;
    int guard;
    logic rdy, rsp;
    logic [31:0] rd;
    dp.valid = 1'b0; dp.waits = 0; dp.first_resp = 1'b0;
    idx = 0; guard = 0;
    present(d, idx);
    while ((idx < tq.size() || dp.valid) && guard < 4000) begin
      guard++;
      @(negedge clk);
      rdy = hreadyout[d]; rsp = hresp[d]; rd = hrdata[d];
      if (dp.valid && !rdy) begin
        dp.waits++;
        if (dp.waits == 1) dp.first_resp = rsp;
      end
      @(posedge clk);
      if (rdy) begin
        if (dp.valid) check_dp(d, dp, rsp, rd);
        dp.valid = 1'b0;
        if (idx < tq.size()) begin
          accept(d, tq[idx], dp);
          idx++;
        end
        #1;
        hwdata[d] = dp.valid ? dp.wdata : $urandom;
        present(d, idx);
      end
    end
    if (guard >= 4000) begin
      n_vec++; n_err++;
      $display("FAIL timeout dut%0d got=%0d cycles expected=<4000", d, guard);
    end
    tq.delete();
  endtask

  // Single transfer, then reset while the slave is stalling its data phase.
  task automatic reset_mid(input int d, input txn_t t, input logic exp_resp_mid);
    hsel[d] = 1'b1; htrans[d] = HTRANS_NONSEQ; hwrite[d] = t.wr;
    haddr[d] = t.addr; hsize[d] = t.size;
    @(posedge clk); #1;
    hsel[d] = 1'b0; htrans[d] = HTRANS_IDLE; hwdata[d] = t.wdata;
    @(negedge clk);
    chk("mid_hreadyout", d, t.addr, {31'h0, hreadyout[d]}, 32'h0);
    chk("mid_hresp", d, t.addr, {31'h0, hresp[d]}, {31'h0, exp_resp_mid});
    rst_n[d] = 1'b0;
    #1;
    chk_reset(d);
    @(posedge clk); #1;
    rst_n[d] = 1'b1;
  endtask

  task automatic rand_run(input int d, input int n);
    for (int w = 0; w < 16; w++) tq.push_back(mk(1'b1, 32'(w * 4), 3'd2, $urandom, 1'b0, 1'b0, 32'h0));
    tq.push_back(mk(1'b1, 32'h6FF8, 3'd2, $urandom, 1'b0, 1'b0, 32'h0));
    tq.push_back(mk(1'b1, 32'h6FFC, 3'd2, $urandom, 1'b0, 1'b0, 32'h0));
    run(d);
    for (int i = 0; i < n; i++) begin
      txn_t t;
      int r;
      int s;
      logic [31:0] a;
      s = $urandom_range(0, 7);
      t = mk(1'($urandom_range(0, 1)), 32'h0,
             (s < 2) ? 3'd0 : (s < 4) ? 3'd1 : (s < 7) ? 3'd2 : 3'd3,
             $urandom, 1'b0, 1'b0, 32'h0);
      a = ($urandom_range(0, 9) == 0) ? 32'h6FF8 + $urandom_range(0, 15) : 32'($urandom_range(0, 63));
      if ($urandom_range(0, 4) != 0 && t.size <= 3'd2) a = a & ~((32'd1 << t.size) - 32'd1);
      t.addr = a;
      r = $urandom_range(0, 9);
      t.trans = (r == 0) ? HTRANS_IDLE : (r == 1) ? HTRANS_BUSY : (r < 6) ? HTRANS_NONSEQ : HTRANS_SEQ;
      t.sel = ($urandom_range(0, 15) != 0);
      tq.push_back(t);
    end
    run(d);
  endtask

  txn_t vec0 [19];
  txn_t vec1 [7];

  initial begin
    vec0[0]  = mk(1'b1, 32'h10,   3'd2, 32'h11223344, 1'b1, 1'b0, 32'h0);
    vec0[1]  = mk(1'b0, 32'h10,   3'd2, 32'h0,        1'b1, 1'b0, 32'h11223344);
    vec0[2]  = mk(1'b1, 32'h13,   3'd0, 32'hAA000000, 1'b1, 1'b0, 32'h0);
    vec0[3]  = mk(1'b1, 32'h10,   3'd1, 32'h0000BEEF, 1'b1, 1'b0, 32'h0);
    vec0[4]  = mk(1'b0, 32'h10,   3'd2, 32'h0,        1'b1, 1'b0, 32'hAA22BEEF);
    vec0[5]  = mk(1'b1, 32'h20,   3'd2, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0);
    vec0[6]  = mk(1'b0, 32'h20,   3'd2, 32'h0,        1'b1, 1'b0, 32'hCAFEF00D);
    vec0[7]  = mk(1'b1, 32'h21,   3'd0, 32'h00005500, 1'b1, 1'b0, 32'h0);
    vec0[8]  = mk(1'b0, 32'h20,   3'd2, 32'h0,        1'b1, 1'b0, 32'hCAFE550D);
    vec0[9]  = mk(1'b1, 32'h24,   3'd2, 32'h01020304, 1'b1, 1'b0, 32'h0);
    vec0[10] = mk(1'b0, 32'h20,   3'd2, 32'h0,        1'b1, 1'b0, 32'hCAFE550D);
    vec0[11] = mk(1'b0, 32'h7000, 3'd2, 32'h0,        1'b1, 1'b1, 32'h0);
    vec0[12] = mk(1'b1, 32'h11,   3'd1, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0);
    vec0[13] = mk_idle();
    vec0[14] = mk(1'b0, 32'h18,   3'd3, 32'h0,        1'b1, 1'b1, 32'h0);
    vec0[15] = mk(1'b1, 32'h7000, 3'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0);
    vec0[16] = mk(1'b0, 32'h10,   3'd2, 32'h0,        1'b1, 1'b0, 32'hAA22BEEF);
    vec0[17] = mk(1'b0, 32'h24,   3'd2, 32'h0,        1'b1, 1'b0, 32'h01020304);
    vec0[18] = mk(1'b0, 32'h13,   3'd0, 32'h0,        1'b1, 1'b0, 32'hAA22BEEF);

    vec1[0]  = mk(1'b1, 32'h10,   3'd2, 32'h11223344, 1'b1, 1'b0, 32'h0);
    vec1[1]  = mk(1'b0, 32'h10,   3'd2, 32'h0,        1'b1, 1'b0, 32'h11223344);
    vec1[2]  = mk(1'b1, 32'h14,   3'd2, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
    vec1[3]  = mk(1'b1, 32'h15,   3'd0, 32'h00007700, 1'b1, 1'b0, 32'h0);
    vec1[4]  = mk(1'b0, 32'h14,   3'd2, 32'h0,        1'b1, 1'b0, 32'hDEAD77EF);
    vec1[5]  = mk(1'b0, 32'h7000, 3'd2, 32'h0,        1'b1, 1'b1, 32'h0);
    vec1[6]  = mk(1'b0, 32'h12,   3'd1, 32'h0,        1'b1, 1'b0, 32'h11223344);

    n_vec = 0; n_err = 0;
    clk = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; hsel[d] = 1'b0; htrans[d] = HTRANS_IDLE; hsize[d] = 3'd0;
      hwrite[d] = 1'b0; haddr[d] = 32'h0; hwdata[d] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset(0);
    chk_reset(1);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk); #1;
    chk_reset(0);
    chk_reset(1);

    for (int i = 0; i < 19; i++) tq.push_back(vec0[i]);
    run(0);
    for (int i = 0; i < 7; i++) tq.push_back(vec1[i]);
    run(1);

    reset_mid(1, mk(1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0), 1'b0);
    tq.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0, 1'b1, 1'b0, 32'h11223344));
    run(1);
    reset_mid(0, mk(1'b1, 32'h11, 3'd1, 32'h12345678, 1'b0, 1'b0, 32'h0), 1'b1);
    tq.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0, 1'b1, 1'b0, 32'hAA22BEEF));
    run(0);

    rand_run(0, 300);
    rand_run(1, 300);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
